id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Pipeline register between decode/register-read and execute in the 64-bit RISC-V core. It captures the register-file read data (ReadData1/ReadData2), register indices, immediate and decoded control for one instruction per cycle and presents them to the ALU stage. It also provides:
- load-use hazard detection with one-cycle stall and bubble insertion;
- branch flush;
- x0 forcing;
- an optional same-cycle writeback bypass, needed because the register file writes on the clock edge but reads combinationally.

## Interface
Parameters:
- XLEN, 64, datapath width
- REG_ADDR_W, 5, register index width
- STALL_CNT_W, 16, width of the stall statistics counter

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- id_valid  in  1  decode presents a valid instruction
- id_ready  out  1  block accepts the decode instruction this cycle
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W  register indices of the decode instruction
- id_rdata1, id_rdata2  in  XLEN  register-file ReadData1/ReadData2
- id_imm  in  XLEN  sign-extended immediate
- id_ctrl  in  CTRL_W  decoded control (ctrl_t)
- wb_regwrite  in  1  writeback RegWrite (same signal driven to the register file)
- wb_rd  in  REG_ADDR_W  writeback destination
- wb_data  in  XLEN  writeback WriteData
- ex_flush  in  1  branch taken/redirect from execute
- ex_valid  out  1  execute-stage instruction valid
- ex_rs1, ex_rs2, ex_rd  out  REG_ADDR_W  registered indices
- ex_rdata1, ex_rdata2  out  XLEN  registered operands
- ex_imm  out  XLEN  registered immediate
- ex_ctrl  out  CTRL_W  registered control; all-zero when ex_valid=0
- stall_cnt  out  STALL_CNT_W  saturating count of load-use stall cycles

## Operation
- **Load-use hazard:** `lu = ex_valid & ex_ctrl.mem_read & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2))`.
- **id_ready:** `id_ready = ~lu | ex_flush`.
- **Next-state priority, per cycle:**
  1. ex_flush=1: load a bubble (ex_valid=0, ex_ctrl=0, indices/data 0). The decode instruction is consumed and discarded, because id_ready=1.
  2. Else lu=1: load a bubble. Decode holds its instruction, because id_ready=0.
  3. Else id_valid=1: capture the id_* fields with ex_valid=1.
  4. Else: load a bubble.
- **Bubble contents:** all ex_* outputs zero.
- **Operand selection** (applied independently to rs1/rdata1 and rs2/rdata2):
  - If the index is 0, capture 0, regardless of register-file contents or bypass.
  - Else, if the bypass is compiled in and `wb_regwrite & (wb_rd == index)`, capture wb_data.
  - Else, capture id_rdataN.
- **stall_cnt:** increments by 1 in each cycle where lu=1 and ex_flush=0. It saturates at all-ones and never wraps. It clears only on reset.
- **Stall length:** a load-use stall lasts exactly one cycle. The inserted bubble has mem_read=0, so lu deasserts the following cycle.

## Timing
- Latency: id_* to ex_* is one clock edge.
- id_ready is combinational from the ex_* registers, id_valid/id_rs*, and ex_flush. There is no combinational path from id_rdata*.
- Reset asserted (low): ex_valid=0, ex_ctrl=0, ex_rs1/rs2/rd=0, ex_rdata1/2=0, ex_imm=0, stall_cnt=0, all asynchronously.
- Reset deassertion: takes effect at the next rising clk.
- id_ready during reset: reflects the cleared ex_valid, so it reads 1.
- Reset mid-stall: the held decode instruction is not captured. Upstream resets concurrently.
- ex_flush and lu in the same cycle: flush wins, and stall_cnt does not increment.
- wb_rd=0 with wb_regwrite=1: never bypassed.

## Configuration
- WB_BYPASS_EN defined:
  - The writeback bypass above is compiled in.
  - A register read in the same cycle it is written yields wb_data.
- WB_BYPASS_EN undefined:
  - No bypass; operands come only from id_rdataN (or 0 for x0).
  - The surrounding pipeline must guarantee no same-cycle read-after-write. The bench skips the bypass scenario.

## Structure
- Shared package cpu_pkg contains:
  - XLEN and REG_ADDR_W constants;
  - typedef ctrl_t as a packed struct of alu_op[3:0], alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch;
  - CTRL_W = $bits(ctrl_t) = 10.
- Sub-module hazard_detect (purely combinational) computes lu from the ex_* and id_* fields. It is reused later by the IF/ID stall logic.

## Test plan
- Reset low mid-traffic -> all ex_* and stall_cnt read 0 immediately; ex_valid stays 0 until the first captured instruction after reset high.
- `ld x5` in EX (mem_read=1, ex_rd=5), decode `add x6,x5,x7` valid -> id_ready=0 for exactly 1 cycle, one bubble (ex_valid=0), then add captured next cycle; stall_cnt 0->1.
- Same hazard with ex_flush=1 -> id_ready=1, bubble loaded, decode instruction dropped, stall_cnt unchanged.
- Decode rs1=0 with id_rdata1=0xDEAD_BEEF_0000_0001 -> ex_rdata1=0.
- WB_BYPASS_EN: wb_regwrite=1, wb_rd=9, wb_data=0x1234, decode rs2=9 with id_rdata2=0x0 -> ex_rdata2=0x1234; with wb_rd=0 -> ex_rdata2 is id_rdata2.
- Force 0xFFFF+2 consecutive load-use stalls (STALL_CNT_W=16) -> stall_cnt holds 0xFFFF, no wrap.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core package: datapath widths and the decoded-control struct used by the
// pipeline registers and hazard logic.
package cpu_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination is a source of the
// valid decode instruction. Shared with the IF/ID stall logic.
module hazard_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  output logic                  lu
);

  assign lu = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
              ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush, x0 forcing and stall counter.
// Define WB_BYPASS_EN to forward same-cycle writeback data into the captured operands.
module id_ex_stage #(
  parameter int XLEN        = cpu_pkg::XLEN,
  parameter int REG_ADDR_W  = cpu_pkg::REG_ADDR_W,
  parameter int STALL_CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  output logic                      id_ready,
  input  logic [REG_ADDR_W-1:0]     id_rs1,
  input  logic [REG_ADDR_W-1:0]     id_rs2,
  input  logic [REG_ADDR_W-1:0]     id_rd,
  input  logic [XLEN-1:0]           id_rdata1,
  input  logic [XLEN-1:0]           id_rdata2,
  input  logic [XLEN-1:0]           id_imm,
  input  logic [cpu_pkg::CTRL_W-1:0] id_ctrl,
  input  logic                      wb_regwrite,
  input  logic [REG_ADDR_W-1:0]     wb_rd,
  input  logic [XLEN-1:0]           wb_data,
  input  logic                      ex_flush,
  output logic                      ex_valid,
  output logic [REG_ADDR_W-1:0]     ex_rs1,
  output logic [REG_ADDR_W-1:0]     ex_rs2,
  output logic [REG_ADDR_W-1:0]     ex_rd,
  output logic [XLEN-1:0]           ex_rdata1,
  output logic [XLEN-1:0]           ex_rdata2,
  output logic [XLEN-1:0]           ex_imm,
  output logic [cpu_pkg::CTRL_W-1:0] ex_ctrl,
  output logic [STALL_CNT_W-1:0]    stall_cnt
);

  import cpu_pkg::*;

  ctrl_t                 ex_ctrl_q;
  logic                  lu;

  logic                  nxt_valid;
  logic [REG_ADDR_W-1:0] nxt_rs1, nxt_rs2, nxt_rd;
  logic [XLEN-1:0]       nxt_rdata1, nxt_rdata2, nxt_imm;
  ctrl_t                 nxt_ctrl;
  logic [XLEN-1:0]       op1, op2;

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl_q.mem_read),
    .ex_rd       (ex_rd),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .lu          (lu)
  );

  assign id_ready = ~lu | ex_flush;
  assign ex_ctrl  = ex_ctrl_q;

  // x0 always reads zero, even when a writeback targets it.
`ifdef WB_BYPASS_EN
  always_comb begin
    op1 = id_rdata1;
    op2 = id_rdata2;
    if (id_rs1 == '0)
      op1 = '0;
    else if (wb_regwrite && (wb_rd == id_rs1))
      op1 = wb_data;
    if (id_rs2 == '0)
      op2 = '0;
    else if (wb_regwrite && (wb_rd == id_rs2))
      op2 = wb_data;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_regwrite, wb_rd, wb_data};

  always_comb begin
    op1 = (id_rs1 == '0) ? '0 : id_rdata1;
    op2 = (id_rs2 == '0) ? '0 : id_rdata2;
  end
`endif

  // Flush and load-use both fall through to the all-zero bubble.
  always_comb begin
    nxt_valid  = 1'b0;
    nxt_rs1    = '0;
    nxt_rs2    = '0;
    nxt_rd     = '0;
    nxt_rdata1 = '0;
    nxt_rdata2 = '0;
    nxt_imm    = '0;
    nxt_ctrl   = '0;
    if (!ex_flush && !lu && id_valid) begin
      nxt_valid  = 1'b1;
      nxt_rs1    = id_rs1;
      nxt_rs2    = id_rs2;
      nxt_rd     = id_rd;
      nxt_rdata1 = op1;
      nxt_rdata2 = op2;
      nxt_imm    = id_imm;
      nxt_ctrl   = ctrl_t'(id_ctrl);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid  <= 1'b0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_rd     <= '0;
      ex_rdata1 <= '0;
      ex_rdata2 <= '0;
      ex_imm    <= '0;
      ex_ctrl_q <= '0;
      stall_cnt <= '0;
    end else begin
      ex_valid  <= nxt_valid;
      ex_rs1    <= nxt_rs1;
      ex_rs2    <= nxt_rs2;
      ex_rd     <= nxt_rd;
      ex_rdata1 <= nxt_rdata1;
      ex_rdata2 <= nxt_rdata2;
      ex_imm    <= nxt_imm;
      ex_ctrl_q <= nxt_ctrl;
      if (lu && !ex_flush && (stall_cnt != '1))
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; the bypass scenario follows WB_BYPASS_EN.
`timescale 1ns/1ps
module tb_id_ex_stage;

  localparam int XLEN  = 64;
  localparam int RW    = 5;
  localparam int CW    = 10;
  // Narrower counter keeps the saturation run short; wrap logic is width-generic.
  localparam int CNT_W = 12;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // {alu_op[3:0], alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch}
  localparam logic [CW-1:0] LD_CTRL  = 10'b0000_1_1_0_1_1_0;
  localparam logic [CW-1:0] ADD_CTRL = 10'b0010_0_0_0_1_0_0;

  logic            clk = 1'b0;
  logic            reset;
  logic            id_valid;
  logic            id_ready;
  logic [RW-1:0]   id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0] id_rdata1, id_rdata2, id_imm;
  logic [CW-1:0]   id_ctrl;
  logic            wb_regwrite;
  logic [RW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            ex_flush;
  logic            ex_valid;
  logic [RW-1:0]   ex_rs1, ex_rs2, ex_rd;
  logic [XLEN-1:0] ex_rdata1, ex_rdata2, ex_imm;
  logic [CW-1:0]   ex_ctrl;
  logic [CNT_W-1:0] stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .REG_ADDR_W(RW), .STALL_CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_flush(ex_flush),
    .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
    .stall_cnt(stall_cnt)
  );

  task automatic set_id(input logic v, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                        input logic [RW-1:0] rd, input logic [XLEN-1:0] d1,
                        input logic [XLEN-1:0] d2, input logic [XLEN-1:0] imm,
                        input logic [CW-1:0] ctrl);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rdata1 = d1; id_rdata2 = d2; id_imm = imm; id_ctrl = ctrl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; ex_flush = 1'b0;
    wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 64'h1, 64'h2, 64'h3, ADD_CTRL);
    tick();
    vectors++;
    if ({ex_valid, ex_rs1, ex_rs2, ex_rd} !== '0) begin
      miscompares++;
      $display("FAIL reset_idx: got v=%b rs1=%0d rs2=%0d rd=%0d want all 0", ex_valid, ex_rs1, ex_rs2, ex_rd);
    end
    vectors++;
    if ({ex_rdata1, ex_rdata2, ex_imm, ex_ctrl} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got d1=%h d2=%h imm=%h ctrl=%h want 0", ex_rdata1, ex_rdata2, ex_imm, ex_ctrl);
    end
    vectors++;
    if (stall_cnt !== '0 || id_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_cnt_ready: got cnt=%0d ready=%b want 0/1", stall_cnt, id_ready);
    end
    set_id(1'b0, '0, '0, '0, '0, '0, '0, '0);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_capture();
    set_id(1'b1, 5'd3, 5'd4, 5'd8, 64'hAAAA_0000_1111_2222, 64'h0123_4567_89AB_CDEF,
           64'hFFFF_FFFF_FFFF_FFF0, ADD_CTRL);
    #1;
    vectors++;
    if (id_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL capture_ready: got %b want 1", id_ready);
    end
    tick();
    vectors++;
    if (ex_valid !== 1'b1 || ex_rs1 !== 5'd3 || ex_rs2 !== 5'd4 || ex_rd !== 5'd8) begin
      miscompares++;
      $display("FAIL capture_idx: got v=%b rs1=%0d rs2=%0d rd=%0d want 1/3/4/8", ex_valid, ex_rs1, ex_rs2, ex_rd);
    end
    vectors++;
    if (ex_rdata1 !== 64'hAAAA_0000_1111_2222 || ex_rdata2 !== 64'h0123_4567_89AB_CDEF ||
        ex_imm !== 64'hFFFF_FFFF_FFFF_FFF0 || ex_ctrl !== ADD_CTRL) begin
      miscompares++;
      $display("FAIL capture_data: got d1=%h d2=%h imm=%h ctrl=%h", ex_rdata1, ex_rdata2, ex_imm, ex_ctrl);
    end
    set_id(1'b0, '0, '0, '0, '0, '0, '0, '0);
    tick();
    vectors++;
    if (ex_valid !== 1'b0 || ex_ctrl !== '0 || ex_rdata1 !== '0) begin
      miscompares++;
      $display("FAIL idle_bubble: got v=%b ctrl=%h d1=%h want 0", ex_valid, ex_ctrl, ex_rdata1);
    end
  endtask

  task automatic test_load_use();
    set_id(1'b1, 5'd2, 5'd0, 5'd5, 64'h100, 64'h0, 64'h8, LD_CTRL);   // ld x5, 8(x2)
    tick();
    set_id(1'b1, 5'd5, 5'd7, 5'd6, 64'h11, 64'h22, 64'h0, ADD_CTRL);  // add x6, x5, x7
    #1;
    vectors++;
    if (id_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL lu_ready: got %b want 0", id_ready);
    end
    tick();
    vectors++;
    if (ex_valid !== 1'b0 || ex_ctrl !== '0 || ex_rd !== '0 || stall_cnt !== 12'd1) begin
      miscompares++;
      $display("FAIL lu_bubble: got v=%b ctrl=%h rd=%0d cnt=%0d want 0/0/0/1", ex_valid, ex_ctrl, ex_rd, stall_cnt);
    end
    vectors++;
    if (id_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL lu_release: got %b want 1", id_ready);
    end
    tick();
    vectors++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_rdata1 !== 64'h11 || ex_ctrl !== ADD_CTRL || stall_cnt !== 12'd1) begin
      miscompares++;
      $display("FAIL lu_capture: got v=%b rd=%0d d1=%h ctrl=%h cnt=%0d", ex_valid, ex_rd, ex_rdata1, ex_ctrl, stall_cnt);
    end
    set_id(1'b0, '0, '0, '0, '0, '0, '0, '0);
    tick();
  endtask

  task automatic test_flush_hazard();
    set_id(1'b1, 5'd2, 5'd0, 5'd5, 64'h100, 64'h0, 64'h8, LD_CTRL);
    tick();
    set_id(1'b1, 5'd5, 5'd7, 5'd6, 64'h11, 64'h22, 64'h0, ADD_CTRL);
    ex_flush = 1'b1;
    #1;
    vectors++;
    if (id_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_ready: got %b want 1", id_ready);
    end
    tick();
    ex_flush = 1'b0;
    set_id(1'b0, '0, '0, '0, '0, '0, '0, '0);
    vectors++;
    if (ex_valid !== 1'b0 || ex_ctrl !== '0 || ex_rd !== '0 || stall_cnt !== 12'd1) begin
      miscompares++;
      $display("FAIL flush_bubble: got v=%b ctrl=%h rd=%0d cnt=%0d want 0/0/0/1", ex_valid, ex_ctrl, ex_rd, stall_cnt);
    end
    // A flush with no hazard also drops a plain valid instruction.
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 64'h5, 64'h6, 64'h7, ADD_CTRL);
    ex_flush = 1'b1;
    tick();
    ex_flush = 1'b0;
    set_id(1'b0, '0, '0, '0, '0, '0, '0, '0);
    vectors++;
    if (ex_valid !== 1'b0 || ex_imm !== '0 || ex_rs1 !== '0) begin
      miscompares++;
      $display("FAIL flush_drop: got v=%b imm=%h rs1=%0d want 0", ex_valid, ex_imm, ex_rs1);
    end
  endtask

  task automatic test_x0();
    set_id(1'b1, 5'd0, 5'd3, 5'd4, 64'hDEAD_BEEF_0000_0001, 64'h55, 64'h0, ADD_CTRL);
    wb_regwrite = 1'b1; wb_rd = 5'd0; wb_data = 64'h9999;
    tick();
    vectors++;
    if (ex_rdata1 !== '0 || ex_rs1 !== '0 || ex_rdata2 !== 64'h55) begin
      miscompares++;
      $display("FAIL x0_force: got d1=%h rs1=%0d d2=%h want 0/0/55", ex_rdata1, ex_rs1, ex_rdata2);
    end
    wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
    set_id(1'b0, '0, '0, '0, '0, '0, '0, '0);
    tick();
  endtask

  task automatic test_bypass();
    wb_regwrite = 1'b1; wb_rd = 5'd9; wb_data = 64'h1234;
    set_id(1'b1, 5'd1, 5'd9, 5'd10, 64'h77, 64'h0, 64'h0, ADD_CTRL);
    tick();
`ifdef WB_BYPASS_EN
    vectors++;
    if (ex_rdata2 !== 64'h1234 || ex_rdata1 !== 64'h77) begin
      miscompares++;
      $display("FAIL bypass_hit: got d2=%h d1=%h want 1234/77", ex_rdata2, ex_rdata1);
    end
`else
    vectors++;
    if (ex_rdata2 !== 64'h0 || ex_rdata1 !== 64'h77) begin
      miscompares++;
      $display("FAIL no_bypass: got d2=%h d1=%h want 0/77", ex_rdata2, ex_rdata1);
    end
`endif
    wb_rd = 5'd0;
    set_id(1'b1, 5'd1, 5'd9, 5'd10, 64'h77, 64'hABCD, 64'h0, ADD_CTRL);
    tick();
    vectors++;
    if (ex_rdata2 !== 64'hABCD) begin
      miscompares++;
      $display("FAIL bypass_wbrd0: got %h want abcd", ex_rdata2);
    end
    wb_regwrite = 1'b0; wb_rd = 5'd9;
    tick();
    vectors++;
    if (ex_rdata2 !== 64'hABCD) begin
      miscompares++;
      $display("FAIL bypass_nowrite: got %h want abcd", ex_rdata2);
    end
    wb_rd = '0; wb_data = '0;
    set_id(1'b0, '0, '0, '0, '0, '0, '0, '0);
    tick();
  endtask

  task automatic test_reset_mid_traffic();
    set_id(1'b1, 5'd2, 5'd0, 5'd5, 64'h100, 64'h0, 64'h8, LD_CTRL);
    tick();
    set_id(1'b1, 5'd5, 5'd7, 5'd6, 64'h11, 64'h22, 64'h0, ADD_CTRL);
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({ex_valid, ex_rs1, ex_rs2, ex_rd, ex_rdata1, ex_rdata2, ex_imm, ex_ctrl} !== '0 || stall_cnt !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got v=%b rd=%0d ctrl=%h cnt=%0d want 0", ex_valid, ex_rd, ex_ctrl, stall_cnt);
    end
    vectors++;
    if (id_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 1", id_ready);
    end
    set_id(1'b0, '0, '0, '0, '0, '0, '0, '0);
    tick();
    reset = 1'b1;
    tick();
    vectors++;
    if (ex_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: got %b want 0", ex_valid);
    end
    set_id(1'b1, 5'd5, 5'd7, 5'd6, 64'h11, 64'h22, 64'h0, ADD_CTRL);
    tick();
    vectors++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_rdata2 !== 64'h22) begin
      miscompares++;
      $display("FAIL post_reset_capture: got v=%b rd=%0d d2=%h want 1/6/22", ex_valid, ex_rd, ex_rdata2);
    end
    set_id(1'b0, '0, '0, '0, '0, '0, '0, '0);
    tick();
  endtask

  task automatic test_saturation();
    int max_stalls;
    max_stalls = int'(CNT_MAX);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    // ld x5, 0(x5) held constant: alternate capture / stall, one stall per two edges.
    set_id(1'b1, 5'd5, 5'd0, 5'd5, 64'h0, 64'h0, 64'h0, LD_CTRL);
    for (int i = 0; i < 2 * (max_stalls - 1); i++) tick();
    vectors++;
    if (stall_cnt !== CNT_MAX - 1'b1) begin
      miscompares++;
      $display("FAIL sat_before: got %0d want %0d", stall_cnt, CNT_MAX - 1'b1);
    end
    for (int i = 0; i < 6; i++) tick();
    vectors++;
    if (stall_cnt !== CNT_MAX) begin
      miscompares++;
      $display("FAIL sat_hold: got %0d want %0d", stall_cnt, CNT_MAX);
    end
    set_id(1'b0, '0, '0, '0, '0, '0, '0, '0);
    tick();
    tick();
    vectors++;
    if (stall_cnt !== CNT_MAX) begin
      miscompares++;
      $display("FAIL sat_idle: got %0d want %0d", stall_cnt, CNT_MAX);
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_load_use();
    test_flush_hazard();
    test_x0();
    test_bypass();
    test_reset_mid_traffic();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
